// File: rtl/if_id_pipe_reg_if.sv
// IF/ID stage bundle: fetch-side and decode-side handshakes, flush, and monitor outputs.
// master = environment (fetch + decode), slave = the pipeline register.
interface if_id_pipe_reg_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CNT_W   = 16
) ();
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  npc;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  npcout;
  logic [INSTR_W-1:0] instrout;
  logic [CNT_W-1:0]   stall_cnt;
  logic [1:0]         occupancy;

  modport master (
    output flush, in_valid, npc, instr, out_ready,
    input  in_ready, out_valid, npcout, instrout, stall_cnt, occupancy
  );

  modport slave (
    input  flush, in_valid, npc, instr, out_ready,
    output in_ready, out_valid, npcout, instrout, stall_cnt, occupancy
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: 2-entry skid buffer carrying {npc, instr} with flush,
// bubble masking and a saturating stall-cycle counter.
module if_id_pipe_reg #(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  if_id_pipe_reg_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  main_npc_q, skid_npc_q;
  logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic main_valid, in_ready, in_fire, out_fire;

  // in_ready depends on registered state only, so no out_ready -> in_ready path.
  assign main_valid = (state_q != StEmpty);
  assign in_ready   = (state_q != StSkid);
  assign in_fire    = bus.in_valid & in_ready;
  assign out_fire   = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      main_npc_q   <= '0;
      main_instr_q <= '0;
      skid_npc_q   <= '0;
      skid_instr_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (main_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      // Flush wins over every transition; stale payload stays but is masked.
      if (bus.flush) begin
        state_q <= StEmpty;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              main_npc_q   <= bus.npc;
              main_instr_q <= bus.instr;
              state_q      <= StFull;
            end
          end
          StFull: begin
            if (in_fire && out_fire) begin
              main_npc_q   <= bus.npc;
              main_instr_q <= bus.instr;
            end else if (in_fire) begin
              skid_npc_q   <= bus.npc;
              skid_instr_q <= bus.instr;
              state_q      <= StSkid;
            end else if (out_fire) begin
              state_q <= StEmpty;
            end
          end
          StSkid: begin
            if (out_fire) begin
              main_npc_q   <= skid_npc_q;
              main_instr_q <= skid_instr_q;
              state_q      <= StFull;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid;
  assign bus.npcout    = main_valid ? main_npc_q : '0;
  assign bus.instrout  = main_valid ? main_instr_q : NOP_INSTR;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    bus.occupancy = 2'd0;
    unique case (state_q)
      StEmpty: bus.occupancy = 2'd0;
      StFull:  bus.occupancy = 2'd1;
      StSkid:  bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

endmodule
